widequeue_unpacker: RTL

Width-down converter that drains a wide queue (WIDE-bit words, default 64) and emits its contents as a stream of NARROW-bit lanes (default 8) to a byte-oriented consumer. Sits directly downstream of the wide generic queue. Pops one wide word at a time through its read strobe and serialises it lane by lane under a valid/ack handshake. Sustains one lane per cycle with no bubble between consecutive words.

---
 rtl/widequeue_unpacker_pkg.sv | 23 ++
 rtl/widequeue_unpacker.sv | 101 ++++++++++
 2 files changed

// File: rtl/widequeue_unpacker_pkg.sv
// Shared definitions for the wide-queue unpacker: state encoding and the
// lane-count and counter-width derivations used to size the datapath.
package widequeue_unpacker_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int lanesOf(input int wide, input int narrow);
    return (narrow > 0) ? (wide / narrow) : 0;
  endfunction

  function automatic int laneCntWidth(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

  // A queue word must split into a whole number of lanes, at least two of them.
  function automatic bit paramsValid(input int wide, input int narrow);
    return (narrow > 0) && (wide % narrow == 0) && (wide / narrow >= 2);
  endfunction

endpackage

// File: rtl/widequeue_unpacker.sv
// Width-down converter: pops one WIDE word from the upstream queue and
// streams it out as NARROW lanes under a valid/ack handshake, bubble-free.
module widequeue_unpacker
  import widequeue_unpacker_pkg::*;
#(
  parameter int WIDE      = 64,
  parameter int NARROW    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDE-1:0]   in_data,
  input  logic              in_ready,
  output logic              in_re,
  output logic [NARROW-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ack
);

  localparam int LANES  = lanesOf(WIDE, NARROW);
  localparam int LANE_W = laneCntWidth(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if (!paramsValid(WIDE, NARROW)) begin : gen_bad_params
    $error("widequeue_unpacker: WIDE must be a multiple of NARROW with at least two lanes");
  end

  state_e            state_q, state_d;
  logic [WIDE-1:0]   hold_q, hold_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              last_q, last_d;
  logic              wordDone;
  logic [WIDE-1:0]   holdShifted;

  assign wordDone    = (state_q == SHIFT) & out_ack & (lane_q == LAST_LANE);
  assign in_re       = ~rst & in_ready & ((state_q == IDLE) | wordDone);
  assign holdShifted = LSB_FIRST ? (hold_q >> NARROW) : (hold_q << NARROW);

  // The shift register always presents the next lane at a fixed end.
  assign out_data  = LSB_FIRST ? hold_q[NARROW-1:0] : hold_q[WIDE-1 -: NARROW];
  assign out_valid = (state_q == SHIFT);
  assign out_last  = last_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (in_ready) begin
          hold_d  = in_data;
          lane_d  = '0;
          last_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ack) begin
          if (lane_q != LAST_LANE) begin
            hold_d = holdShifted;
            lane_d = lane_q + 1'b1;
            last_d = ((lane_q + 1'b1) == LAST_LANE);
          end else if (in_ready) begin
            hold_d = in_data;
            lane_d = '0;
            last_d = 1'b0;
          end else begin
            // Clearing the holding register keeps out_data at zero while idle.
            hold_d  = '0;
            lane_d  = '0;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        lane_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

endmodule
